avalon_pkt_fifo: RTL
====================

Name: avalon_pkt_fifo

Overview:
Store-and-forward packet FIFO that sits directly downstream of the Avalon-ST enforcer and consumes its trusted stream. It buffers whole packets and presents a packet on the output only once its EOP word is stored, so downstream stages never see a partial packet. Packets that cannot fit are dropped whole and flagged. The input never back-pressures the enforcer.

Parameters:
DATA_W, 64, data bus width in bits
EMPTY_W, 3, width of empty field (log2 of DATA_W/8)
DEPTH, 16, buffer depth in words; power of 2, minimum 4

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  asynchronous, active-low reset
in_data  input  DATA_W  input word
in_valid  input  1  input word valid
in_sop  input  1  start of packet, qualified by in_valid
in_eop  input  1  end of packet, qualified by in_valid
in_empty  input  EMPTY_W  empty bytes on EOP word
in_ready  output  1  tied to 1 after reset; words are accepted when in_valid=1
out_data  output  DATA_W  output word
out_valid  output  1  committed word available
out_ready  input  1  downstream accept
out_sop  output  1  start of packet
out_eop  output  1  end of packet
out_empty  output  EMPTY_W  empty bytes on EOP word
pkt_count  output  $clog2(DEPTH)+1  committed packets not yet fully read
drop_pulse  output  1  one-cycle pulse when a packet is dropped

Behaviour:
- Reset (rst=0, async): pointers=0, state IDLE, pkt_count=0, drop_pulse=0, out_valid=0, in_ready=0. in_ready goes to 1 on the first clk edge after rst deasserts.
- Storage: DEPTH entries of {data, sop, eop, empty}. Pointers wr_ptr, wr_start (commit boundary) and rd_ptr, each $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH. used = wr_ptr - rd_ptr. full when used == DEPTH.
- Write FSM states: IDLE, IN_PKT, DROP.
  - IDLE: word with sop=1 is written. If eop=1 too (single word), commit: wr_start <= wr_ptr+1. Otherwise go to IN_PKT. A word with sop=0 is discarded silently.
  - IN_PKT: each word is written. On eop, commit and go to IDLE. A word with sop=1 restarts the packet: wr_ptr rewinds to wr_start, the word is written as a new first word, and drop_pulse=1.
  - Any accepted word while full (IDLE or IN_PKT): wr_ptr <= wr_start, drop_pulse=1 for one cycle. Go to DROP, or to IDLE if that word has eop=1.
  - DROP: all words are discarded until and including eop, then IDLE. A sop in DROP is treated as in IDLE.
  - Packets longer than DEPTH are always dropped. A packet of exactly DEPTH words fits when the buffer is empty.
- Read side (show-ahead):
  - out_valid = (rd_ptr != wr_start); the out_* fields are mem[rd_ptr].
  - Transfer occurs when out_valid & out_ready; rd_ptr increments.
  - Latency: EOP accepted at edge N gives out_valid=1 in the cycle after edge N.
  - Uncommitted words are never visible on the output.
- pkt_count: +1 on commit, -1 on transfer of an eop word, unchanged when both occur in the same cycle.
- Simultaneous read and write in the same cycle are allowed. Space freed by a read is visible to the write side only on the next cycle.
- Reset mid-packet clears everything. The partial packet is lost with no drop_pulse.

Optional Feature:
PKT_FIFO_STATS_EN:
- Defined: adds outputs pkt_in_cnt[15:0] (committed packets) and pkt_drop_cnt[15:0] (drop_pulse events). Both are saturating at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist.

Test Plan:
- DEPTH=16, one 4-word packet (sop on word 0, eop on word 3, empty=2), out_ready=1 -> out_valid rises in the cycle after word 3 is accepted; 4 words out in order, out_empty=2 on the last; pkt_count goes 1 then 0.
- Single-word packet (sop=eop=1) -> one output word with sop=eop=1; pkt_count peaks at 1.
- out_ready=0, write 3 packets of 5 words, then a 4-word packet -> first three commit (used=15); fourth overflows at its 2nd word, drop_pulse=1 once; after draining, exactly 15 words and 3 packets are output.
- 20-word packet into empty DEPTH=16 FIFO -> dropped at word 17, drop_pulse once, no output, pkt_count=0; the next 2-word packet passes intact.
- sop mid-packet (3 words, then new sop, 2 words with eop) -> drop_pulse=1; output carries only the 2-word packet.
- Reset asserted mid-packet and while out_valid=1 -> all outputs return to reset values immediately; the next packet after reset passes normally.

Source files
------------

// File: rtl/avalon_pkt_fifo.sv
// Store-and-forward Avalon-ST packet FIFO: packets become visible only once their EOP is stored.
// Define PKT_FIFO_STATS_EN to add saturating committed/dropped packet counters.
module avalon_pkt_fifo #(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3,
    parameter int DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic [EMPTY_W-1:0]       in_empty,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [EMPTY_W-1:0]       out_empty,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic                     drop_pulse
`ifdef PKT_FIFO_STATS_EN
    ,
    output logic [15:0]              pkt_in_cnt,
    output logic [15:0]              pkt_drop_cnt
`endif
);
    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = AW + 1;
    localparam int WORD_W = DATA_W + 2 + EMPTY_W;

    typedef enum logic [1:0] {S_IDLE, S_IN_PKT, S_DROP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   wr_start_q, wr_start_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   pkt_count_q, pkt_count_d;
    logic            drop_q, drop_d;
    logic            in_ready_q;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] word_in, rd_word;
    logic [AW-1:0]     mem_waddr;
    logic              mem_we, commit, full, rd_xfer;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    assign word_in   = {in_data, in_sop, in_eop, in_empty};
    assign rd_word   = mem[rd_ptr_q[AW-1:0]];
    assign out_data  = rd_word[WORD_W-1 -: DATA_W];
    assign out_sop   = rd_word[EMPTY_W+1];
    assign out_eop   = rd_word[EMPTY_W];
    assign out_empty = rd_word[EMPTY_W-1:0];
    assign out_valid = (rd_ptr_q != wr_start_q);
    assign in_ready  = in_ready_q;
    assign pkt_count = pkt_count_q;
    assign drop_pulse = drop_q;

    // Fullness uses the registered read pointer, so space freed by a read appears a cycle later.
    assign full    = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
    assign rd_xfer = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_start_d = wr_start_q;
        drop_d     = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr_q[AW-1:0];
        commit     = 1'b0;
        if (in_valid && in_ready_q) begin
            if (state_q != S_IN_PKT) begin
                if (in_sop) begin
                    if (full) begin
                        drop_d   = 1'b1;
                        wr_ptr_d = wr_start_q;
                        state_d  = in_eop ? S_IDLE : S_DROP;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (in_eop) begin
                            commit     = 1'b1;
                            wr_start_d = wr_ptr_q + PW'(1);
                            state_d    = S_IDLE;
                        end else begin
                            state_d = S_IN_PKT;
                        end
                    end
                end else if (state_q == S_DROP && in_eop) begin
                    state_d = S_IDLE;
                end
            end else if (full) begin
                drop_d   = 1'b1;
                wr_ptr_d = wr_start_q;
                state_d  = in_eop ? S_IDLE : S_DROP;
            end else if (in_sop) begin
                // Restart: discard the partial packet and reuse its slot for the new first word.
                drop_d    = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = wr_start_q[AW-1:0];
                wr_ptr_d  = wr_start_q + PW'(1);
                if (in_eop) begin
                    commit     = 1'b1;
                    wr_start_d = wr_start_q + PW'(1);
                    state_d    = S_IDLE;
                end
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                if (in_eop) begin
                    commit     = 1'b1;
                    wr_start_d = wr_ptr_q + PW'(1);
                    state_d    = S_IDLE;
                end
            end
        end

        rd_ptr_d = rd_xfer ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({commit, rd_xfer & out_eop})
            2'b10:   pkt_count_d = pkt_count_q + PW'(1);
            2'b01:   pkt_count_d = pkt_count_q - PW'(1);
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            wr_start_q  <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            drop_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_start_q  <= wr_start_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            drop_q      <= drop_d;
            in_ready_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= word_in;
    end

`ifdef PKT_FIFO_STATS_EN
    logic [15:0] pkt_in_cnt_q, pkt_drop_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_in_cnt_q   <= '0;
            pkt_drop_cnt_q <= '0;
        end else begin
            pkt_in_cnt_q   <= sat_inc(pkt_in_cnt_q, commit);
            pkt_drop_cnt_q <= sat_inc(pkt_drop_cnt_q, drop_d);
        end
    end

    assign pkt_in_cnt   = pkt_in_cnt_q;
    assign pkt_drop_cnt = pkt_drop_cnt_q;
`endif

endmodule
